// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per cycle.
// mode selects restoring (0) or non-restoring (1) iteration; divide-by-zero completes in one cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH:0]   a, a_sh, a_sub, a_it, a_fix, m_ext;
  logic [WIDTH-1:0] q, q_sh, q_it, m;
  logic [5:0]       cnt;
  logic             mode_r, load, last;

  assign m_ext = {1'b0, m};
  assign busy  = (state == RUN) || (state == FIX);
  assign done  = (state == DONE);
  assign load  = start && ((state == IDLE) || (state == DONE));
  assign last  = (cnt == 6'(WIDTH - 1));

  // The top bit of A is dropped by the shift; arithmetic stays correct modulo
  // 2^(WIDTH+1) because every post-add/subtract value fits the signed range.
  always_comb begin
    a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
    q_sh  = {q[WIDTH-2:0], 1'b0};
    a_sub = a_sh - m_ext;
    a_it  = a_sub;
    q_it  = q_sh;
    if (!mode_r) begin
      if (a_sub[WIDTH]) begin
        a_it = a_sh;
        q_it = q_sh;
      end else begin
        a_it = a_sub;
        q_it = q_sh | WIDTH'(1);
      end
    end else begin
      a_it = a[WIDTH] ? (a_sh + m_ext) : a_sub;
      q_it = {q_sh[WIDTH-1:1], ~a_it[WIDTH]};
    end
    a_fix = a[WIDTH] ? (a + m_ext) : a;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (last) nxt = mode_r ? FIX : DONE;
      FIX:  nxt = DONE;
      DONE: nxt = start ? ((divisor == '0) ? DONE : RUN) : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      cnt         <= '0;
      mode_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        a           <= '0;
        q           <= dividend;
        m           <= divisor;
        mode_r      <= mode;
        cnt         <= '0;
        div_by_zero <= (divisor == '0);
        if (divisor == '0) begin
          quotient  <= '0;
          remainder <= dividend;
        end
      end else if (state == RUN) begin
        a   <= a_it;
        q   <= q_it;
        cnt <= cnt + 6'd1;
        if (last && !mode_r) begin
          quotient  <= q_it;
          remainder <= a_it[WIDTH-1:0];
        end
      end else if (state == FIX) begin
        a         <= a_fix;
        quotient  <= q;
        remainder <= a_fix[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: WIDTH=8 directed vectors plus exhaustive WIDTH=4 sweep.
module tb_seq_divider;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, mode, busy, done, dbz;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       s4, m4, busy4, done4, z4;
  logic [3:0] dd4, dv4, q4, r4;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
  );

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .mode(m4),
    .dividend(dd4), .divisor(dv4), .busy(busy4), .done(done4),
    .quotient(q4), .remainder(r4), .div_by_zero(z4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int l0, output int lat);
    lat = l0;
    while (!done && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                         input logic md, input int exp_lat, input logic [7:0] eq,
                         input logic [7:0] er, input logic ez);
    int lat;
    dividend = dd; divisor = dv; mode = md; start = 1'b1;
    tick();
    start = 1'b0;
    dividend = ~dd; divisor = ~dv; mode = ~md;
    chk({tag, " busy after accept"}, 64'(busy), 64'(exp_lat > 1));
    chk({tag, " done after accept"}, 64'(done), 64'(exp_lat == 1));
    wait_done(1, lat);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " quotient"}, 64'(quotient), 64'(eq));
    chk({tag, " remainder"}, 64'(remainder), 64'(er));
    chk({tag, " div_by_zero"}, 64'(dbz), 64'(ez));
  endtask

  initial begin
    int lat, ndone, eq, er;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; dividend = '0; divisor = '0;
    s4 = 1'b0; m4 = 1'b0; dd4 = '0; dv4 = '0;
    tick(); tick();
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset quotient", 64'(quotient), 64'(0));
    chk("reset remainder", 64'(remainder), 64'(0));
    chk("reset dbz", 64'(dbz), 64'(0));
    rst_n = 1'b1;
    tick();

    run_div("200/7 r", 8'd200, 8'd7, 1'b0, 9, 8'd28, 8'd4, 1'b0);
    run_div("200/7 nr", 8'd200, 8'd7, 1'b1, 10, 8'd28, 8'd4, 1'b0);
    run_div("13/0", 8'd13, 8'd0, 1'b0, 1, 8'd0, 8'd13, 1'b1);
    run_div("255/255 r", 8'd255, 8'd255, 1'b0, 9, 8'd1, 8'd0, 1'b0);
    run_div("255/255 nr", 8'd255, 8'd255, 1'b1, 10, 8'd1, 8'd0, 1'b0);
    run_div("5/9 r", 8'd5, 8'd9, 1'b0, 9, 8'd0, 8'd5, 1'b0);
    run_div("5/9 nr", 8'd5, 8'd9, 1'b1, 10, 8'd0, 8'd5, 1'b0);
    run_div("255/1 r", 8'd255, 8'd1, 1'b0, 9, 8'd255, 8'd0, 1'b0);
    run_div("255/1 nr", 8'd255, 8'd1, 1'b1, 10, 8'd255, 8'd0, 1'b0);

    tick(); tick(); tick();
    chk("hold quotient", 64'(quotient), 64'(255));
    chk("hold remainder", 64'(remainder), 64'(0));
    chk("idle done", 64'(done), 64'(0));

    // start while busy must be dropped
    dividend = 8'd50; divisor = 8'd6; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    dividend = 8'd100; divisor = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, lat);
    chk("busy-start latency", 64'(lat), 64'(9));
    chk("busy-start quotient", 64'(quotient), 64'(8));
    chk("busy-start remainder", 64'(remainder), 64'(2));
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("busy-start extra done", 64'(ndone), 64'(0));

    // reset mid-operation
    dividend = 8'd200; divisor = 8'd7; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0; start = 1'b1;
    tick();
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst quotient", 64'(quotient), 64'(0));
    chk("midrst remainder", 64'(remainder), 64'(0));
    chk("midrst dbz", 64'(dbz), 64'(0));
    start = 1'b0; rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("midrst no done", 64'(ndone), 64'(0));
    run_div("9/2 after rst", 8'd9, 8'd2, 1'b0, 9, 8'd4, 8'd1, 1'b0);

    // back-to-back: each run_div starts in the DONE cycle of the previous one
    run_div("b2b 100/3 nr", 8'd100, 8'd3, 1'b1, 10, 8'd33, 8'd1, 1'b0);
    run_div("b2b 17/0", 8'd17, 8'd0, 1'b0, 1, 8'd0, 8'd17, 1'b1);
    run_div("b2b 77/10 r", 8'd77, 8'd10, 1'b0, 9, 8'd7, 8'd7, 1'b0);

    // exhaustive 4-bit sweep, back-to-back in both modes
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int md = 0; md < 2; md++) begin
          dd4 = 4'(a); dv4 = 4'(b); m4 = md[0]; s4 = 1'b1;
          tick();
          s4 = 1'b0;
          chk("w4 busy", 64'(busy4), 64'(b != 0));
          lat = 0;
          while (!done4 && lat < 20) begin
            tick();
            lat++;
          end
          eq = (b == 0) ? 0 : a / b;
          er = (b == 0) ? a : a % b;
          chk("w4 done", 64'(done4), 64'(1));
          chk("w4 quotient", 64'(q4), 64'(eq));
          chk("w4 remainder", 64'(r4), 64'(er));
          chk("w4 dbz", 64'(z4), 64'(b == 0));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
